trap_controller: RTL and testbench

- Consumer of the fetch-stage and execute-stage exception codes produced by the exception signal handler.
- Carries the fetch-stage code down the pipeline alongside its instruction, so every trap is taken precisely, in E.
- Arbitrates between causes, latches mepc/mcause/mtval, flushes F/D/E and redirects the PC to the trap vector. Handles mret.
- Owns the permission state (reset / trap) that the exception handler consumes as i_reset_permission / i_trap_permission.

---
 rtl/trap_controller.sv | 197 +++++++++++++++++++
 tb/tb_trap_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Precise trap controller: carries fetch-stage exception codes to E, arbitrates causes,
// latches mepc/mcause/mtval, redirects to the trap vector and handles mret.
// Optional macro TRAP_COUNT_EN adds a saturating o_trap_count output.

package trap_pkg;
    localparam logic [3:0] E_FETCH_ADDR_MISALIGNED = 4'd0;
    localparam logic [3:0] E_FETCH_ACCESS_FAULT    = 4'd1;
    localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
    localparam logic [3:0] E_BREAKPOINT            = 4'd3;
    localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
    localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
    localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
    localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd7;
    localparam logic [3:0] E_ECALL                 = 4'd11;
    localparam logic [3:0] NO_E                    = 4'd15;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_NORMAL,
        ST_IN_TRAP,
        ST_HALT
    } trap_state_e;
endpackage

module trap_controller
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0004_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0000,
    parameter logic [31:0] TEXT_BASE    = 32'h0008_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_exception_code_f,
    input  logic [31:0] i_pc_f,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_flush_e,
    input  logic [3:0]  i_exception_code_e,
    input  logic [31:0] i_pc_e,
    input  logic [31:0] i_alu_out_e,
    input  logic        i_mret_e,
    output logic        o_flush_fde,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_mepc,
    output logic [31:0] o_mcause,
    output logic [31:0] o_mtval,
    output logic        o_reset_permission,
    output logic        o_trap_permission,
    output logic        o_halt
`ifdef TRAP_COUNT_EN
    ,
    output logic [31:0] o_trap_count
`endif
);

    trap_state_e state_q;
    logic [3:0]  code_d_q, code_x_q;
    logic [31:0] pc_d_q, pc_x_q;
    logic [31:0] mepc_q, mcause_q, mtval_q;
    logic        reset_perm_q, trap_perm_q, halt_q;

    logic        cause_valid;
    logic [3:0]  cause;
    logic [31:0] cause_pc;
    logic [31:0] cause_tval;
    logic        take;
    logic        mret_ok;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cause_valid = 1'b0;
        cause       = NO_E;
        cause_pc    = 32'h0;
        cause_tval  = 32'h0;
        if (code_x_q != NO_E) begin
            cause_valid = 1'b1;
            cause       = code_x_q;
            cause_pc    = pc_x_q;
            cause_tval  = pc_x_q;
        end else if (i_exception_code_e != NO_E) begin
            cause_valid = 1'b1;
            cause       = i_exception_code_e;
            cause_pc    = i_pc_e;
            if (i_exception_code_e inside {E_LOAD_ADDR_MISALIGNED, E_LOAD_ACCESS_FAULT,
                                           E_STORE_ADDR_MISALIGNED, E_STORE_ACCESS_FAULT})
                cause_tval = i_alu_out_e;
        end else if (i_mret_e && state_q == ST_NORMAL) begin
            cause_valid = 1'b1;
            cause       = E_ILLEGAL_INSTR;
            cause_pc    = i_pc_e;
        end
    end

    assign take    = cause_valid && (state_q != ST_HALT);
    assign mret_ok = i_mret_e && !cause_valid && (state_q == ST_RESET || state_q == ST_IN_TRAP);

    // A nested trap halts silently: no flush or redirect toward a handler that already failed.
    always_comb begin
        o_flush_fde      = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = RESET_VECTOR;
        if (take && state_q != ST_IN_TRAP) begin
            o_flush_fde      = 1'b1;
            o_redirect_valid = 1'b1;
            o_redirect_pc    = TRAP_VECTOR;
        end else if (mret_ok) begin
            o_flush_fde      = 1'b1;
            o_redirect_valid = 1'b1;
            o_redirect_pc    = (state_q == ST_RESET) ? TEXT_BASE : mepc_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            code_d_q <= NO_E;
            pc_d_q   <= 32'h0;
            code_x_q <= NO_E;
            pc_x_q   <= 32'h0;
        end else begin
            if (i_flush_d || o_flush_fde) begin
                code_d_q <= NO_E;
            end else if (!i_stall_d) begin
                code_d_q <= i_exception_code_f;
                pc_d_q   <= i_pc_f;
            end
            if (i_flush_e || o_flush_fde) begin
                code_x_q <= NO_E;
            end else begin
                code_x_q <= code_d_q;
                pc_x_q   <= pc_d_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_RESET;
            mepc_q       <= 32'h0;
            mcause_q     <= 32'h0;
            mtval_q      <= 32'h0;
            reset_perm_q <= 1'b1;
            trap_perm_q  <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET, ST_NORMAL: begin
                    if (take) begin
                        state_q      <= ST_IN_TRAP;
                        mepc_q       <= cause_pc;
                        mcause_q     <= {28'b0, cause};
                        mtval_q      <= cause_tval;
                        reset_perm_q <= 1'b0;
                        trap_perm_q  <= 1'b1;
                    end else if (mret_ok) begin
                        state_q      <= ST_NORMAL;
                        reset_perm_q <= 1'b0;
                        trap_perm_q  <= 1'b0;
                    end
                end
                ST_IN_TRAP: begin
                    if (take) begin
                        state_q <= ST_HALT;
                        halt_q  <= 1'b1;
                    end else if (mret_ok) begin
                        state_q     <= ST_NORMAL;
                        trap_perm_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRAP_COUNT_EN
    logic [31:0] trap_count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            trap_count_q <= 32'h0;
        else if (take && trap_count_q != 32'hFFFF_FFFF)
            trap_count_q <= trap_count_q + 32'd1;
    end

    assign o_trap_count = trap_count_q;
`endif

    assign o_mepc             = mepc_q;
    assign o_mcause           = mcause_q;
    assign o_mtval            = mtval_q;
    assign o_reset_permission = reset_perm_q;
    assign o_trap_permission  = trap_perm_q;
    assign o_halt             = halt_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: reset exit, fetch/execute traps, squash, priority,
// illegal mret, nested-trap halt and recovery by reset.

module tb_trap_controller;
    import trap_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  code_f, code_e;
    logic [31:0] pc_f, pc_e, alu;
    logic        stall_d, flush_d, flush_e, mret;
    logic        flush_fde, redirect_valid, reset_perm, trap_perm, halt;
    logic [31:0] redirect_pc, mepc, mcause, mtval;
`ifdef TRAP_COUNT_EN
    logic [31:0] trap_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    trap_controller dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_exception_code_f (code_f),
        .i_pc_f             (pc_f),
        .i_stall_d          (stall_d),
        .i_flush_d          (flush_d),
        .i_flush_e          (flush_e),
        .i_exception_code_e (code_e),
        .i_pc_e             (pc_e),
        .i_alu_out_e        (alu),
        .i_mret_e           (mret),
        .o_flush_fde        (flush_fde),
        .o_redirect_valid   (redirect_valid),
        .o_redirect_pc      (redirect_pc),
        .o_mepc             (mepc),
        .o_mcause           (mcause),
        .o_mtval            (mtval),
        .o_reset_permission (reset_perm),
        .o_trap_permission  (trap_perm),
        .o_halt             (halt)
`ifdef TRAP_COUNT_EN
        ,
        .o_trap_count       (trap_count)
`endif
    );

    task automatic next();
        @(negedge clk);
    endtask

    task automatic idle();
        code_f = NO_E; pc_f = 32'h0; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
        code_e = NO_E; pc_e = 32'h0; alu = 32'h0; mret = 1'b0;
    endtask

    task automatic leave_trap(input logic [31:0] exp_pc);
        mret = 1'b1; #1;
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL mret_valid: got %b expected 1", redirect_valid); end
        checks++; if (redirect_pc !== exp_pc) begin errors++; $display("FAIL mret_pc: got %h expected %h", redirect_pc, exp_pc); end
        checks++; if (flush_fde !== 1'b1) begin errors++; $display("FAIL mret_flush: got %b expected 1", flush_fde); end
        next(); mret = 1'b0;
        checks++; if ({reset_perm, trap_perm} !== 2'b00) begin errors++; $display("FAIL mret_perms: got %b expected 00", {reset_perm, trap_perm}); end
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1;
        next(); next(); rst = 1'b0; #1;
        checks++; if ({reset_perm, trap_perm, halt} !== 3'b100) begin errors++; $display("FAIL reset_flags: got %b expected 100", {reset_perm, trap_perm, halt}); end
        checks++; if ({mepc, mcause, mtval} !== 96'h0) begin errors++; $display("FAIL reset_csrs: got %h expected 0", {mepc, mcause, mtval}); end
        checks++; if ({flush_fde, redirect_valid} !== 2'b00) begin errors++; $display("FAIL reset_flush: got %b expected 00", {flush_fde, redirect_valid}); end
`ifdef TRAP_COUNT_EN
        checks++; if (trap_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", trap_count); end
`endif
        // Leaving the reset region goes to user text.
        leave_trap(32'h0008_0000);
    endtask

    task automatic test_fetch_trap();
        code_f = E_FETCH_ADDR_MISALIGNED; pc_f = 32'h0008_0012;
        next(); code_f = NO_E; pc_f = 32'h0008_0016; #1;
        checks++; if (flush_fde !== 1'b0) begin errors++; $display("FAIL fetch_early: got %b expected 0", flush_fde); end
        next(); #1;
        checks++; if ({flush_fde, redirect_valid} !== 2'b11) begin errors++; $display("FAIL fetch_take: got %b expected 11", {flush_fde, redirect_valid}); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL fetch_vector: got %h expected 0", redirect_pc); end
        next(); idle(); exp_count++;
        checks++; if (mepc !== 32'h0008_0012) begin errors++; $display("FAIL fetch_mepc: got %h expected 00080012", mepc); end
        checks++; if (mtval !== 32'h0008_0012) begin errors++; $display("FAIL fetch_mtval: got %h expected 00080012", mtval); end
        checks++; if (mcause !== 32'd0) begin errors++; $display("FAIL fetch_mcause: got %h expected 0", mcause); end
        checks++; if ({reset_perm, trap_perm} !== 2'b01) begin errors++; $display("FAIL fetch_perms: got %b expected 01", {reset_perm, trap_perm}); end
        checks++; if (flush_fde !== 1'b0) begin errors++; $display("FAIL fetch_after: got %b expected 0", flush_fde); end
        leave_trap(32'h0008_0012);
    endtask

    task automatic test_exec_trap();
        code_e = E_LOAD_ACCESS_FAULT; pc_e = 32'h0008_0040; alu = 32'h0000_1234; #1;
        checks++; if ({flush_fde, redirect_valid} !== 2'b11) begin errors++; $display("FAIL exec_take: got %b expected 11", {flush_fde, redirect_valid}); end
        next(); idle(); exp_count++;
        checks++; if (mepc !== 32'h0008_0040) begin errors++; $display("FAIL exec_mepc: got %h expected 00080040", mepc); end
        checks++; if (mtval !== 32'h0000_1234) begin errors++; $display("FAIL exec_mtval: got %h expected 00001234", mtval); end
        checks++; if (mcause !== 32'd5) begin errors++; $display("FAIL exec_mcause: got %h expected 5", mcause); end
        leave_trap(32'h0008_0040);
    endtask

    task automatic test_mret();
        code_e = E_ECALL; pc_e = 32'h0008_0044; alu = 32'hDEAD_BEEF;
        next(); idle(); exp_count++;
        checks++; if (mepc !== 32'h0008_0044) begin errors++; $display("FAIL ecall_mepc: got %h expected 00080044", mepc); end
        checks++; if (mtval !== 32'h0) begin errors++; $display("FAIL ecall_mtval: got %h expected 0", mtval); end
        checks++; if (mcause !== 32'd11) begin errors++; $display("FAIL ecall_mcause: got %h expected b", mcause); end
        leave_trap(32'h0008_0044);
    endtask

    task automatic test_squash();
        code_f = E_ILLEGAL_INSTR; pc_f = 32'h0008_0050; flush_d = 1'b1; #1;
        checks++; if (flush_fde !== 1'b0) begin errors++; $display("FAIL squash_d0: got %b expected 0", flush_fde); end
        next(); idle(); code_f = E_ILLEGAL_INSTR; pc_f = 32'h0008_0054;
        next(); code_f = NO_E; flush_e = 1'b1; #1;
        checks++; if (flush_fde !== 1'b0) begin errors++; $display("FAIL squash_d1: got %b expected 0", flush_fde); end
        next(); flush_e = 1'b0; #1;
        checks++; if (flush_fde !== 1'b0) begin errors++; $display("FAIL squash_e: got %b expected 0", flush_fde); end
        next();
        checks++; if (trap_perm !== 1'b0) begin errors++; $display("FAIL squash_perm: got %b expected 0", trap_perm); end
    endtask

    task automatic test_priority();
        code_f = E_FETCH_ACCESS_FAULT; pc_f = 32'h0008_0100;
        next(); code_f = NO_E;
        next(); code_e = E_STORE_ACCESS_FAULT; pc_e = 32'h0008_0104; alu = 32'h0000_9999; mret = 1'b1; #1;
        checks++; if ({flush_fde, redirect_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL prio_take: got %b/%h expected 1/0", flush_fde, redirect_pc); end
        next(); idle(); exp_count++;
        checks++; if ({mcause, mepc, mtval} !== {32'd1, 32'h0008_0100, 32'h0008_0100}) begin errors++; $display("FAIL prio_csrs: got %h %h %h expected 1 00080100 00080100", mcause, mepc, mtval); end
        leave_trap(32'h0008_0100);
    endtask

    task automatic test_mret_normal();
        mret = 1'b1; pc_e = 32'h0008_0060; #1;
        checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL illmret_take: got %b/%h expected 1/0", redirect_valid, redirect_pc); end
        next(); idle(); exp_count++;
        checks++; if ({mcause, mepc, mtval} !== {32'd2, 32'h0008_0060, 32'h0}) begin errors++; $display("FAIL illmret_csrs: got %h %h %h expected 2 00080060 0", mcause, mepc, mtval); end
        checks++; if (trap_perm !== 1'b1) begin errors++; $display("FAIL illmret_perm: got %b expected 1", trap_perm); end
    endtask

    task automatic test_halt();
        code_e = E_ECALL; pc_e = 32'h0008_0070; #1;
        checks++; if ({flush_fde, redirect_valid} !== 2'b00) begin errors++; $display("FAIL nest_flush: got %b expected 00", {flush_fde, redirect_valid}); end
        next(); idle(); exp_count++;
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL nest_halt: got %b expected 1", halt); end
        checks++; if ({mepc, mcause} !== {32'h0008_0060, 32'd2}) begin errors++; $display("FAIL nest_csrs: got %h %h expected 00080060 2", mepc, mcause); end
        mret = 1'b1; code_e = E_LOAD_ACCESS_FAULT; #1;
        checks++; if ({flush_fde, redirect_valid} !== 2'b00) begin errors++; $display("FAIL halt_frozen: got %b expected 00", {flush_fde, redirect_valid}); end
        next(); next(); idle();
        checks++; if ({halt, mepc} !== {1'b1, 32'h0008_0060}) begin errors++; $display("FAIL halt_hold: got %b %h expected 1 00080060", halt, mepc); end
`ifdef TRAP_COUNT_EN
        checks++; if (trap_count !== exp_count) begin errors++; $display("FAIL trap_count: got %0d expected %0d", trap_count, exp_count); end
`endif
        rst = 1'b1; next(); rst = 1'b0;
        checks++; if ({halt, reset_perm, trap_perm} !== 3'b010) begin errors++; $display("FAIL rerst_flags: got %b expected 010", {halt, reset_perm, trap_perm}); end
        checks++; if ({mepc, mcause, mtval} !== 96'h0) begin errors++; $display("FAIL rerst_csrs: got %h expected 0", {mepc, mcause, mtval}); end
`ifdef TRAP_COUNT_EN
        checks++; if (trap_count !== 32'd0) begin errors++; $display("FAIL rerst_count: got %0d expected 0", trap_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_trap();
        test_exec_trap();
        test_mret();
        test_squash();
        test_priority();
        test_mret_normal();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
